// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with a single-outstanding data memory
// access FSM. A memory op holds EX/MEM (stall_o) from the IDLE cycle it is
// seen until the access completes. MEM/WB then loads the instruction together
// with the captured read data.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, a misaligned LW/SW
// raises exc_o for one cycle instead of accessing memory.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access outstanding; a memory op on the inputs starts one
// BUSY  | request on the memory port, waiting for dm_ack_i
// DONE  | read data captured; MEM/WB loads the instruction next edge
module mem_access_stage (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_dreg_i,
    input  logic [63:0] mem_dhilo_i,
    output logic        dm_req_o,
    output logic [3:0]  dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_din_o,
    input  logic [31:0] dm_rdata_i,
    input  logic        dm_ack_i,
    output logic [4:0]  wb_wa_o,
    output logic        wb_wreg_o,
    output logic        wb_whilo_o,
    output logic        wb_mreg_o,
    output logic [31:0] wb_dreg_o,
    output logic [63:0] wb_dhilo_o,
    output logic [3:0]  wb_dre_o,
    output logic [31:0] wb_dm_o,
    output logic        stall_o,
    output logic        exc_o
);

    localparam logic [2:0] OP_LB = 3'b001;
    localparam logic [2:0] OP_LW = 3'b010;
    localparam logic [2:0] OP_SB = 3'b011;
    localparam logic [2:0] OP_SW = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] load_reg;

    logic        is_lb, is_lw, is_sb, is_sw;
    logic        is_load, is_store, is_mem;
    logic        misalign;
    logic        start;
    logic [3:0]  lane_onehot;
    logic [3:0]  req_we;
    logic [31:0] req_din;
    logic [3:0]  load_dre;

    assign is_lb    = (mem_op_i == OP_LB);
    assign is_lw    = (mem_op_i == OP_LW);
    assign is_sb    = (mem_op_i == OP_SB);
    assign is_sw    = (mem_op_i == OP_SW);
    assign is_load  = is_lb | is_lw;
    assign is_store = is_sb | is_sw;
    assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_lw | is_sw) && (mem_addr_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
    assign exc_o    = 1'b0;
`endif

    assign start   = (state == IDLE) && is_mem && !misalign;
    assign stall_o = cpu_rst_n && (start || (state == BUSY));

    // Byte-lane decode: lane n carries byte offset n of the word.
    always_comb begin
        lane_onehot = 4'b0001 << mem_addr_i[1:0];
        req_we      = 4'b0000;
        req_din     = 32'h0;
        load_dre    = 4'b0000;
        if (is_sb) begin
            req_we  = lane_onehot;
            req_din = {4{mem_sdata_i[7:0]}};
        end else if (is_sw) begin
            req_we  = 4'b1111;
            req_din = {mem_sdata_i[7:0], mem_sdata_i[15:8],
                       mem_sdata_i[23:16], mem_sdata_i[31:24]};
        end
        if (is_lb)
            load_dre = lane_onehot;
        else if (is_lw)
            load_dre = 4'b1111;
    end

    // Access FSM, memory request registers and MEM/WB register.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state      <= IDLE;
            load_reg   <= 32'h0;
            dm_req_o   <= 1'b0;
            dm_we_o    <= 4'b0000;
            dm_addr_o  <= 32'h0;
            dm_din_o   <= 32'h0;
            wb_wa_o    <= 5'd0;
            wb_wreg_o  <= 1'b0;
            wb_whilo_o <= 1'b0;
            wb_mreg_o  <= 1'b0;
            wb_dreg_o  <= 32'h0;
            wb_dhilo_o <= 64'h0;
            wb_dre_o   <= 4'b0000;
            wb_dm_o    <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
            exc_o      <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            exc_o <= (state == IDLE) && misalign;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        dm_req_o  <= 1'b1;
                        dm_we_o   <= req_we;
                        dm_addr_o <= {mem_addr_i[31:2], 2'b00};
                        dm_din_o  <= req_din;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (dm_ack_i) begin
                        load_reg  <= dm_rdata_i;
                        dm_req_o  <= 1'b0;
                        dm_we_o   <= 4'b0000;
                        dm_addr_o <= 32'h0;
                        dm_din_o  <= 32'h0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Stalled edges and rejected accesses insert a bubble; DONE
            // retires the memory op; anything else in IDLE flows straight through.
            if (stall_o || ((state == IDLE) && misalign)) begin
                wb_wa_o    <= 5'd0;
                wb_wreg_o  <= 1'b0;
                wb_whilo_o <= 1'b0;
                wb_mreg_o  <= 1'b0;
                wb_dreg_o  <= 32'h0;
                wb_dhilo_o <= 64'h0;
                wb_dre_o   <= 4'b0000;
                wb_dm_o    <= 32'h0;
            end else if (state == DONE) begin
                wb_wa_o    <= mem_wa_i;
                wb_wreg_o  <= is_load ? mem_wreg_i : 1'b0;
                wb_whilo_o <= mem_whilo_i;
                wb_mreg_o  <= is_load;
                wb_dreg_o  <= mem_dreg_i;
                wb_dhilo_o <= mem_dhilo_i;
                wb_dre_o   <= load_dre;
                wb_dm_o    <= load_reg;
            end else begin
                wb_wa_o    <= mem_wa_i;
                wb_wreg_o  <= mem_wreg_i;
                wb_whilo_o <= mem_whilo_i;
                wb_mreg_o  <= 1'b0;
                wb_dreg_o  <= mem_dreg_i;
                wb_dhilo_o <= mem_dhilo_i;
                wb_dre_o   <= 4'b0000;
                wb_dm_o    <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_sdata, mem_dreg, dm_rdata;
    logic [4:0]  mem_wa;
    logic        mem_wreg, mem_whilo, dm_ack;
    logic [63:0] mem_dhilo;
    logic        dm_req_o;
    logic [3:0]  dm_we_o;
    logic [31:0] dm_addr_o, dm_din_o;
    logic [4:0]  wb_wa_o;
    logic        wb_wreg_o, wb_whilo_o, wb_mreg_o;
    logic [31:0] wb_dreg_o, wb_dm_o;
    logic [63:0] wb_dhilo_o;
    logic [3:0]  wb_dre_o;
    logic        stall_o, exc_o;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    mem_access_stage dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
        .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_sdata_i(mem_sdata),
        .mem_wa_i(mem_wa), .mem_wreg_i(mem_wreg), .mem_whilo_i(mem_whilo),
        .mem_dreg_i(mem_dreg), .mem_dhilo_i(mem_dhilo),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_din_o(dm_din_o), .dm_rdata_i(dm_rdata), .dm_ack_i(dm_ack),
        .wb_wa_o(wb_wa_o), .wb_wreg_o(wb_wreg_o), .wb_whilo_o(wb_whilo_o),
        .wb_mreg_o(wb_mreg_o), .wb_dreg_o(wb_dreg_o), .wb_dhilo_o(wb_dhilo_o),
        .wb_dre_o(wb_dre_o), .wb_dm_o(wb_dm_o),
        .stall_o(stall_o), .exc_o(exc_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wa,
                         input logic wreg, input logic [31:0] dreg);
        mem_op    = op;
        mem_addr  = addr;
        mem_sdata = sdata;
        mem_wa    = wa;
        mem_wreg  = wreg;
        mem_whilo = 1'b0;
        mem_dreg  = dreg;
        mem_dhilo = 64'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
        drive(3'b010, 32'h10, 32'h0, 5'd1, 1'b1, 32'h55);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b exp 0", stall_o); end
        step(); step();
        checks++; if (dm_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", dm_req_o); end
        checks++; if ({wb_wa_o, wb_wreg_o, wb_dreg_o, wb_dm_o, wb_dre_o} !== '0) begin errors++; $display("FAIL reset_wb: got nonzero wb outputs wb_dreg=%h", wb_dreg_o); end
        checks++; if (exc_o !== 1'b0) begin errors++; $display("FAIL reset_exc: got %0b exp 0", exc_o); end
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        int stalls = 0;
        drive(3'b010, 32'h10, 32'h0, 5'd5, 1'b1, 32'hDEAD);
        #1; if (stall_o) stalls++;
        step();
        if (stall_o) stalls++;
        checks++; if (dm_req_o !== 1'b1) begin errors++; $display("FAIL lw_req: got %0b exp 1", dm_req_o); end
        checks++; if (dm_addr_o !== 32'h10 || dm_we_o !== 4'b0000) begin errors++; $display("FAIL lw_reqfields: addr=%h we=%b exp 10/0000", dm_addr_o, dm_we_o); end
        dm_ack = 1'b1; dm_rdata = 32'h11223344;
        step();
        if (stall_o) stalls++;
        dm_ack = 1'b0; dm_rdata = 32'h0;
        checks++; if (dm_req_o !== 1'b0) begin errors++; $display("FAIL lw_req_drop: got %0b exp 0", dm_req_o); end
        checks++; if (stalls != 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d exp 2", stalls); end
        step();
        checks++; if (wb_dm_o !== 32'h11223344) begin errors++; $display("FAIL lw_dm: got %h exp 11223344", wb_dm_o); end
        checks++; if (wb_dre_o !== 4'b1111 || wb_mreg_o !== 1'b1 || wb_wreg_o !== 1'b1 || wb_wa_o !== 5'd5) begin errors++; $display("FAIL lw_wb: dre=%b mreg=%0b wreg=%0b wa=%0d exp 1111/1/1/5", wb_dre_o, wb_mreg_o, wb_wreg_o, wb_wa_o); end
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++; #1; if (stall_o !== 1'b0 || dm_req_o !== 1'b0) begin errors++; $display("FAIL lw_no_reissue: stall=%0b req=%0b exp 0/0", stall_o, dm_req_o); end
        step();
    endtask

    task automatic test_sb();
        drive(3'b011, 32'h23, 32'h000000AB, 5'd7, 1'b1, 32'h0);
        step();
        checks++; if (dm_we_o !== 4'b1000 || dm_din_o !== 32'hABABABAB || dm_addr_o !== 32'h20) begin errors++; $display("FAIL sb_req: we=%b din=%h addr=%h exp 1000/ABABABAB/20", dm_we_o, dm_din_o, dm_addr_o); end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        step();
        checks++; if (wb_wreg_o !== 1'b0 || wb_mreg_o !== 1'b0 || wb_dre_o !== 4'b0000) begin errors++; $display("FAIL sb_wb: wreg=%0b mreg=%0b dre=%b exp 0/0/0000", wb_wreg_o, wb_mreg_o, wb_dre_o); end
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 32'h100, 32'h0, 5'(i + 1), 1'b1, vals[i]);
            mem_dhilo = {vals[i], ~vals[i]};
            if (i == 2) mem_op = 3'b111;
            #1;
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d: got %0b exp 0", i, stall_o); end
            step();
            checks++; if (wb_dreg_o !== vals[i] || wb_wa_o !== 5'(i + 1) || wb_wreg_o !== 1'b1 || wb_dhilo_o !== {vals[i], ~vals[i]}) begin errors++; $display("FAIL b2b_wb%0d: dreg=%h wa=%0d exp %h/%0d", i, wb_dreg_o, wb_wa_o, vals[i], i + 1); end
            checks++; if (dm_req_o !== 1'b0 || wb_mreg_o !== 1'b0 || wb_dre_o !== 4'b0000) begin errors++; $display("FAIL b2b_ctl%0d: req=%0b mreg=%0b dre=%b exp 0/0/0000", i, dm_req_o, wb_mreg_o, wb_dre_o); end
        end
    endtask

    task automatic test_lb_delay();
        drive(3'b001, 32'h01, 32'h0, 5'd9, 1'b1, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (dm_req_o !== 1'b1 || dm_addr_o !== 32'h0 || stall_o !== 1'b1) begin errors++; $display("FAIL lb_hold%0d: req=%0b addr=%h stall=%0b exp 1/0/1", i, dm_req_o, dm_addr_o, stall_o); end
            checks++; if (wb_dreg_o !== 32'h0 || wb_wreg_o !== 1'b0 || wb_wa_o !== 5'd0) begin errors++; $display("FAIL lb_bubble%0d: dreg=%h wreg=%0b exp 0/0", i, wb_dreg_o, wb_wreg_o); end
            dm_ack = (i == 4);
            dm_rdata = (i == 4) ? 32'h00005A00 : 32'hFFFFFFFF;
            step();
        end
        dm_ack = 1'b0;
        step();
        checks++; if (wb_dre_o !== 4'b0010 || wb_dm_o !== 32'h00005A00 || wb_mreg_o !== 1'b1) begin errors++; $display("FAIL lb_wb: dre=%b dm=%h mreg=%0b exp 0010/00005A00/1", wb_dre_o, wb_dm_o, wb_mreg_o); end
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_ack_ignored();
        drive(3'b000, 32'h0, 32'h0, 5'd3, 1'b1, 32'h77);
        dm_ack = 1'b1; dm_rdata = 32'hFEEDFACE;
        step();
        dm_ack = 1'b0;
        checks++; if (dm_req_o !== 1'b0 || wb_mreg_o !== 1'b0 || wb_dm_o !== 32'h0 || wb_dreg_o !== 32'h77) begin errors++; $display("FAIL idle_ack: req=%0b mreg=%0b dm=%h dreg=%h exp 0/0/0/77", dm_req_o, wb_mreg_o, wb_dm_o, wb_dreg_o); end
    endtask

    task automatic test_reset_busy();
        drive(3'b010, 32'h40, 32'h0, 5'd4, 1'b1, 32'h99);
        step();
        checks++; if (dm_req_o !== 1'b1) begin errors++; $display("FAIL rb_req: got %0b exp 1", dm_req_o); end
        rst_n = 1'b0;
        step();
        checks++; if (dm_req_o !== 1'b0 || stall_o !== 1'b0 || {wb_wa_o, wb_wreg_o, wb_mreg_o, wb_dreg_o, wb_dre_o, wb_dm_o} !== '0) begin errors++; $display("FAIL rb_cleared: req=%0b stall=%0b dreg=%h exp all 0", dm_req_o, stall_o, wb_dreg_o); end
        rst_n = 1'b1;
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        dm_ack = 1'b1; dm_rdata = 32'h12345678;
        step();
        dm_ack = 1'b0;
        step();
        checks++; if (dm_req_o !== 1'b0 || stall_o !== 1'b0 || wb_mreg_o !== 1'b0 || wb_dm_o !== 32'h0) begin errors++; $display("FAIL rb_late_ack: req=%0b stall=%0b mreg=%0b dm=%h exp 0/0/0/0", dm_req_o, stall_o, wb_mreg_o, wb_dm_o); end
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
        drive(3'b000, 32'h0, 32'h0, 5'd2, 1'b1, 32'h31);
        step();
        drive(3'b100, 32'h06, 32'h12345678, 5'd2, 1'b1, 32'h31);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL align_stall: got %0b exp 0", stall_o); end
        step();
        checks++; if (dm_req_o !== 1'b0 || exc_o !== 1'b1) begin errors++; $display("FAIL align_exc: req=%0b exc=%0b exp 0/1", dm_req_o, exc_o); end
        checks++; if (wb_wreg_o !== 1'b0 || wb_dreg_o !== 32'h0) begin errors++; $display("FAIL align_bubble: wreg=%0b dreg=%h exp 0/0", wb_wreg_o, wb_dreg_o); end
        drive(3'b000, 32'h0, 32'h0, 5'd2, 1'b1, 32'h31);
        step();
        checks++; if (exc_o !== 1'b0 || dm_req_o !== 1'b0 || wb_dreg_o !== 32'h31) begin errors++; $display("FAIL align_after: exc=%0b req=%0b dreg=%h exp 0/0/31", exc_o, dm_req_o, wb_dreg_o); end
`else
        drive(3'b100, 32'h06, 32'h12345678, 5'd2, 1'b1, 32'h0);
        step();
        checks++; if (dm_req_o !== 1'b1 || dm_addr_o !== 32'h04 || dm_we_o !== 4'b1111 || dm_din_o !== 32'h78563412) begin errors++; $display("FAIL sw_req: req=%0b addr=%h we=%b din=%h exp 1/04/1111/78563412", dm_req_o, dm_addr_o, dm_we_o, dm_din_o); end
        checks++; if (exc_o !== 1'b0) begin errors++; $display("FAIL sw_exc: got %0b exp 0", exc_o); end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        step();
        checks++; if (wb_wreg_o !== 1'b0 || wb_mreg_o !== 1'b0 || exc_o !== 1'b0) begin errors++; $display("FAIL sw_wb: wreg=%0b mreg=%0b exc=%0b exp 0/0/0", wb_wreg_o, wb_mreg_o, exc_o); end
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_back_to_back();
        test_lb_delay();
        test_ack_ignored();
        test_reset_busy();
        test_align();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
